fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage of the pipelined mini-CPU. It owns the PC and issues requests to instruction memory over a ready handshake. It captures returned words into the IF/ID register that drives the decoder's inst input. It applies stall, branch (beq) and jump redirects, and flushes wrong-path words to NOP (32'h0).

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.
NOP_WORD, 32'h0000_0000, word driven on inst when flushed or invalid.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hazard hold; freezes PC and IF/ID.
br_taken  in  1  branch resolved taken (beq & zero).
br_target  in  32  branch target address.
jmp  in  1  jump (j) in ID.
jmp_index  in  26  inst[25:0] of the jump.
im_req  out  1  instruction memory request.
im_addr  out  32  word address of the request.
im_ready  in  1  memory accepts the request; im_rdata is valid in the same cycle.
im_rdata  in  32  instruction word.
inst  out  32  IF/ID instruction to the decoder.
inst_valid  out  1  inst holds a real fetched word.
pc_out  out  32  address of inst.
pc_plus4  out  32  pc_out + 4.

Behaviour:
- Reset (async, immediate):
  - pc = RESET_PC; state = BOOT.
  - inst = NOP_WORD; inst_valid = 0; pc_out = RESET_PC.
  - im_req = 0; skid register cleared.
- States: BOOT, FETCH, HOLD, DRAIN.
- BOOT: im_req = 0 for exactly one cycle, then FETCH.
- FETCH:
  - im_req = 1; im_addr = pc.
  - im_addr is held stable while im_req & !im_ready.
  - On im_ready & !stall & no redirect: inst <= im_rdata, inst_valid <= 1, pc_out <= pc, pc <= pc + 4. Stay in FETCH.
  - On im_ready & stall & no redirect: skid <= im_rdata; skid_pc <= pc; go to HOLD.
- With zero-wait memory (im_ready tied 1), throughput is one instruction per cycle and latency is one cycle from im_addr to inst.
- HOLD:
  - im_req = 0; inst and pc_out are frozen.
  - When stall drops: inst <= skid, inst_valid <= 1, pc_out <= skid_pc, pc <= skid_pc + 4, go to FETCH.
- Stall with no response pending (FETCH, !im_ready): the request stays asserted. A response that arrives during the stall goes to HOLD.
- When stall is high, inst, inst_valid, pc_out and pc_plus4 never change, except on redirect.
- Redirect:
  - Redirect = br_taken | jmp. br_taken has priority over jmp (older instruction).
  - Target = br_target, or {pc_plus4[31:28], jmp_index, 2'b00} for a jump. Bits [1:0] of any target are forced to 00.
  - Redirect has priority over stall.
  - Same cycle as the redirect: inst <= NOP_WORD, inst_valid <= 0, pc <= target, skid discarded.
  - If a request is outstanding and im_ready = 0: go to DRAIN and keep im_addr at the old pc.
  - Otherwise (im_ready = 1 or im_req = 0): go to FETCH, and the next im_addr = target.
- DRAIN:
  - im_req = 1 with the old address.
  - On im_ready the data is discarded; go to FETCH with im_addr = target.
  - A further redirect in DRAIN overwrites the target and stays in DRAIN.
  - inst_valid stays 0.
- Arithmetic: pc + 4 is 32-bit wrap-around; 32'hFFFF_FFFC + 4 = 0.
- pc_plus4 is combinational from pc_out.
- Reset asserted in any state, including DRAIN with a request pending, returns to BOOT. A memory response arriving during or after reset is ignored.

Test Plan:
1. Release reset with im_ready = 1 → BOOT cycle with im_req = 0. Then im_addr = 0, 4, 8 on consecutive cycles. inst equals the memory words one cycle later; pc_out = 0, 4, 8; inst_valid rises on the first word.
2. stall = 1 for 3 cycles while im_addr = 8 and im_ready = 1 → inst/pc_out hold at word@4/4, im_req = 0 during HOLD. After release: inst = word@8, pc_out = 8, next im_addr = 12.
3. br_taken = 1, br_target = 32'h0000_0043 while fetching 0x10 → next cycle inst = 0, inst_valid = 0, im_addr = 0x40. One cycle later inst = word@0x40.
4. jmp = 1, pc_out = 32'h1000_1004, jmp_index = 26'h0000100 → next im_addr = 32'h1000_0400. Same case with br_taken = 1 and br_target = 0x80 → im_addr = 0x80 (branch wins).
5. im_ready delayed 3 cycles, redirect to 0x200 issued in wait cycle 1 → im_addr stays at the old pc until im_ready. That data is never on inst; then im_addr = 0x200.
6. Assert rst_n = 0 mid-DRAIN → inst = 0, inst_valid = 0, im_req = 0 immediately. After release: one BOOT cycle, then im_addr = RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from instruction memory
// and fills the IF/ID register, handling stalls, branch/jump redirects and flushes.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [25:0] jmp_index,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] im_addr_q, im_addr_d;
    logic        im_req_q, im_req_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        redirect_s;
    logic [31:0] target_raw_s;
    logic [31:0] target_s;

    assign im_req     = im_req_q;
    assign im_addr    = im_addr_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc_out     = pc_out_q;
    assign pc_plus4   = pc_out_q + 32'd4;

    // Redirect target selection; the older branch wins over the jump.
    always_comb begin
        redirect_s = br_taken | jmp;
        if (br_taken) begin
            target_raw_s = br_target;
        end else begin
            target_raw_s = {pc_plus4[31:28], jmp_index, 2'b00};
        end
        target_s = target_raw_s & 32'hFFFF_FFFC;
    end

    // Next-state logic; a redirect overrides stall and every state action.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        im_addr_d    = im_addr_q;
        im_req_d     = im_req_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        pc_out_d     = pc_out_q;
        skid_d       = skid_q;
        skid_pc_d    = skid_pc_q;
        if (redirect_s) begin
            inst_d       = NOP_WORD;
            inst_valid_d = 1'b0;
            pc_d         = target_s;
            skid_d       = NOP_WORD;
            // An unanswered request must complete at its old address before refetching.
            if (im_req_q && !im_ready) begin
                state_d = DRAIN;
            end else begin
                state_d   = FETCH;
                im_req_d  = 1'b1;
                im_addr_d = target_s;
            end
        end else begin
            case (state_q)
                BOOT: begin
                    state_d   = FETCH;
                    im_req_d  = 1'b1;
                    im_addr_d = pc_q;
                end
                FETCH: begin
                    if (im_ready && !stall) begin
                        inst_d       = im_rdata;
                        inst_valid_d = 1'b1;
                        pc_out_d     = pc_q;
                        pc_d         = pc_q + 32'd4;
                        im_addr_d    = pc_q + 32'd4;
                    end else if (im_ready) begin
                        skid_d    = im_rdata;
                        skid_pc_d = pc_q;
                        im_req_d  = 1'b0;
                        state_d   = HOLD;
                    end else begin
                        state_d = FETCH;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_d       = skid_q;
                        inst_valid_d = 1'b1;
                        pc_out_d     = skid_pc_q;
                        pc_d         = skid_pc_q + 32'd4;
                        im_addr_d    = skid_pc_q + 32'd4;
                        im_req_d     = 1'b1;
                        state_d      = FETCH;
                    end else begin
                        state_d = HOLD;
                    end
                end
                DRAIN: begin
                    if (im_ready) begin
                        im_addr_d = pc_q;
                        state_d   = FETCH;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                default: begin
                    state_d  = BOOT;
                    im_req_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            im_addr_q    <= RESET_PC;
            im_req_q     <= 1'b0;
            inst_q       <= NOP_WORD;
            inst_valid_q <= 1'b0;
            pc_out_q     <= RESET_PC;
            skid_q       <= NOP_WORD;
            skid_pc_q    <= RESET_PC;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            im_addr_q    <= im_addr_d;
            im_req_q     <= im_req_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            pc_out_q     <= pc_out_d;
            skid_q       <= skid_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule
